shift_reg_test_sequencer: RTL and testbench

- Sequences a 74299-style 8-bit universal shift/storage register through a fixed self-test: parallel load, right shifts, left shifts, hold.
- Drives the DUT mode, serial and parallel inputs, and models the expected register contents cycle by cycle.
- Compares the DUT parallel output against the model and reports an error count plus pass/fail.
- Sits between the test-bench top (start/abort/status) and the DUT.

---
 rtl/shift_reg_test_sequencer_if.sv | 23 ++
 rtl/shift_reg_test_sequencer.sv | 171 +++++++++++++++++
 tb/tb_shift_reg_test_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_test_sequencer_if.sv
// Bus between the self-test sequencer and a 74299-style universal shift register:
// mode, serial fill and parallel load lines out, parallel output back.
interface shift_reg_test_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             s1;
  logic             s0;
  logic             dsr;
  logic             dsl;
  logic [WIDTH-1:0] par_d;
  logic             oe_n;
  logic [WIDTH-1:0] dut_q;

  modport master (
    output s1, s0, dsr, dsl, par_d, oe_n,
    input  dut_q
  );

  modport slave (
    input  s1, s0, dsr, dsl, par_d, oe_n,
    output dut_q
  );
endinterface

// File: rtl/shift_reg_test_sequencer.sv
// Fixed self-test sequencer for a 74299-style shift register: load, shift right, shift left, hold.
// Define SHIFT_REG_TEST_SELFCHECK_EN to build the expected-value model, comparator and error counter.
module shift_reg_test_sequencer #(
  parameter int WIDTH     = 8,
  parameter int SHIFT_CNT = 8,
  parameter int ERR_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [WIDTH-1:0]         pattern,
  input  logic                     dsr_val,
  input  logic                     dsl_val,
  shift_reg_test_sequencer_if.master dut_bus,
  output logic                     busy,
  output logic                     done,
  output logic [ERR_W-1:0]         err_cnt,
  output logic                     pass
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SHR   = 3'd2;
  localparam logic [2:0] ST_SHL   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  localparam logic [15:0] SHIFT_LAST = 16'(SHIFT_CNT - 1);

  logic [2:0]       state;
  logic [15:0]      cnt;
  logic [WIDTH-1:0] pat_r;
  logic             dsr_r;
  logic             dsl_r;
  logic             start_acc;

  assign start_acc = (state == ST_IDLE) && start;

  // Sequencing: the counter times both shift phases and the two-cycle hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (abort && (state != ST_IDLE)) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          state <= ST_SHR;
          cnt   <= SHIFT_LAST;
        end
        ST_SHR: begin
          if (cnt == '0) begin
            state <= ST_SHL;
            cnt   <= SHIFT_LAST;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_SHL: begin
          if (cnt == '0) begin
            state <= ST_HOLD;
            cnt   <= 16'd1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) state <= ST_DRAIN;
          else           cnt   <= cnt - 16'd1;
        end
        ST_DRAIN: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Run parameters are captured once per accepted start and held for the whole run.
  always_ff @(posedge clk) begin
    if (rst_n && start_acc) begin
      pat_r <= pattern;
      dsr_r <= dsr_val;
      dsl_r <= dsl_val;
    end
  end

  always_comb begin
    dut_bus.s1    = 1'b0;
    dut_bus.s0    = 1'b0;
    dut_bus.dsr   = 1'b0;
    dut_bus.dsl   = 1'b0;
    dut_bus.par_d = '0;
    dut_bus.oe_n  = 1'b1;
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
    if (state != ST_IDLE) begin
      dut_bus.dsr = dsr_r;
      dut_bus.dsl = dsl_r;
    end
    case (state)
      ST_LOAD: begin
        dut_bus.s1    = 1'b1;
        dut_bus.s0    = 1'b1;
        dut_bus.par_d = pat_r;
        dut_bus.oe_n  = 1'b0;
      end
      ST_SHR: begin
        dut_bus.s0   = 1'b1;
        dut_bus.oe_n = 1'b0;
      end
      ST_SHL: begin
        dut_bus.s1   = 1'b1;
        dut_bus.oe_n = 1'b0;
      end
      ST_HOLD, ST_DRAIN: dut_bus.oe_n = 1'b0;
      default: ;
    endcase
  end

`ifdef SHIFT_REG_TEST_SELFCHECK_EN
  logic [WIDTH-1:0] expect_q;
  logic [ERR_W-1:0] err_q;
  logic             cmp_en;
  logic             mismatch;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  // Each compare sees the DUT after the previous cycle's operation.
  assign cmp_en   = (state == ST_SHR) || (state == ST_SHL) ||
                    (state == ST_HOLD) || (state == ST_DRAIN);
  assign mismatch = cmp_en && (dut_bus.dut_q != expect_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      expect_q <= '0;
    end else begin
      case (state)
        ST_LOAD: expect_q <= pat_r;
        ST_SHR:  expect_q <= {dsr_r, expect_q[WIDTH-1:1]};
        ST_SHL:  expect_q <= {expect_q[WIDTH-2:0], dsl_r};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)        err_q <= '0;
    else if (start_acc) err_q <= '0;
    else if (mismatch)  err_q <= sat_inc(err_q);
  end

  assign err_cnt = err_q;
  assign pass    = (err_q == '0);
`else
  logic unused_dut_q;

  assign unused_dut_q = ^dut_bus.dut_q;
  assign err_cnt      = '0;
  assign pass         = 1'b1;
`endif

endmodule

// File: tb/tb_shift_reg_test_sequencer.sv
// Directed bench for shift_reg_test_sequencer with a behavioural 74299 and a per-cycle scoreboard.
// Expected error counts depend on whether SHIFT_REG_TEST_SELFCHECK_EN is defined.
module tb_shift_reg_test_sequencer;
  localparam int S = 8;

`ifdef SHIFT_REG_TEST_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic       dsr_val;
  logic       dsl_val;
  logic       busy, done, pass;
  logic [7:0] err_cnt;
  logic       busy4, done4, pass4;
  logic [3:0] err_cnt4;
  logic [7:0] model_q;
  logic [7:0] faulty_q;
  int         fault;
  int         tests_run;
  int         fails;
  logic [14:0] exp_q[$];

  shift_reg_test_sequencer_if #(.WIDTH(8)) bus ();
  shift_reg_test_sequencer_if #(.WIDTH(8)) bus4 ();

  shift_reg_test_sequencer #(.WIDTH(8), .SHIFT_CNT(S), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pattern(pattern),
    .dsr_val(dsr_val), .dsl_val(dsl_val), .dut_bus(bus), .busy(busy), .done(done),
    .err_cnt(err_cnt), .pass(pass)
  );

  shift_reg_test_sequencer #(.WIDTH(8), .SHIFT_CNT(S), .ERR_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pattern(pattern),
    .dsr_val(dsr_val), .dsl_val(dsl_val), .dut_bus(bus4), .busy(busy4), .done(done4),
    .err_cnt(err_cnt4), .pass(pass4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural 74299 driven by the first sequencer; both sequencers see the same output.
  initial model_q = 8'h00;
  always_ff @(posedge clk) begin
    case ({bus.s1, bus.s0})
      2'b11:   model_q <= bus.par_d;
      2'b01:   model_q <= {bus.dsr, model_q[7:1]};
      2'b10:   model_q <= {model_q[6:0], bus.dsl};
      default: ;
    endcase
  end

  assign faulty_q   = (fault == 1) ? 8'hAA : (fault == 2) ? (model_q | 8'h01) : model_q;
  assign bus.dut_q  = faulty_q;
  assign bus4.dut_q = faulty_q;

  wire [14:0] obs  = {bus.s1, bus.s0, bus.oe_n, busy, done, bus.dsr, bus.dsl, bus.par_d};
  wire [14:0] obs4 = {bus4.s1, bus4.s0, bus4.oe_n, busy4, done4, bus4.dsr, bus4.dsl, bus4.par_d};

  // Expected drive for cycle c after the start edge (c=0 means idle).
  function automatic logic [14:0] exp_vec(int c, logic [7:0] p, logic dr, logic dl);
    logic [1:0] m;
    logic       oe, bz, dn;
    logic [7:0] pd;
    m = 2'b00; oe = 1'b1; bz = 1'b0; dn = 1'b0; pd = 8'h00;
    if (c >= 1 && c <= 2*S+5) begin
      bz = 1'b1;
      if (c <= 2*S+4) oe = 1'b0;
    end
    if (c == 1) begin
      m  = 2'b11;
      pd = p;
    end else if (c >= 2 && c <= S+1) begin
      m = 2'b01;
    end else if (c >= S+2 && c <= 2*S+1) begin
      m = 2'b10;
    end
    if (c == 2*S+5) dn = 1'b1;
    return {m, oe, bz, dn, bz & dr, bz & dl, pd};
  endfunction

  task automatic check(string tag, logic [31:0] o, logic [31:0] e);
    tests_run++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(logic [7:0] p, logic dr, logic dl, int last);
    for (int c = 1; c <= last; c++) exp_q.push_back(exp_vec(c, p, dr, dl));
  endtask

  task automatic push_idle(int n);
    for (int i = 0; i < n; i++) exp_q.push_back(exp_vec(0, 8'h00, 1'b0, 1'b0));
  endtask

  task automatic chk_n(int n);
    logic [14:0] e;
    for (int i = 0; i < n; i++) begin
      step();
      if (exp_q.size() == 0) begin
        tests_run++;
        fails++;
        $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      end else begin
        e = exp_q.pop_front();
        check("drive", 32'(obs), 32'(e));
        check("drive4", 32'(obs4), 32'(e));
      end
    end
  endtask

  task automatic chk_err(string tag, int e, int e4);
    check(tag, {23'd0, err_cnt, pass}, {23'd0, 8'(e), (e == 0)});
    check({tag, "_w4"}, {27'd0, err_cnt4, pass4}, {27'd0, 4'(e4), (e4 == 0)});
  endtask

  task automatic run_full(string tag, logic [7:0] p, logic dr, logic dl, int e, int e4);
    pattern = p; dsr_val = dr; dsl_val = dl; start = 1'b1;
    push_run(p, dr, dl, 2*S+5);
    push_idle(1);
    chk_n(1);
    start = 1'b0;
    chk_err({tag, "_clear"}, 0, 0);
    chk_n(2*S+4);
    chk_err({tag, "_done"}, e, e4);
    chk_n(1);
    chk_err({tag, "_after"}, e, e4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run = 0; fails = 0; fault = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = 8'h00; dsr_val = 1'b0; dsl_val = 1'b0;
    repeat (3) step();
    check("reset_drive", 32'(obs), 32'(exp_vec(0, 8'h00, 1'b0, 1'b0)));
    chk_err("reset_err", 0, 0);
    rst_n = 1'b1;
    step();

    // Ideal DUT, then stuck output, then bit 0 stuck high.
    run_full("ideal", 8'hAA, 1'b1, 1'b0, 0, 0);
    fault = 1;
    run_full("stuck", 8'hAA, 1'b1, 1'b0, SC ? 18 : 0, SC ? 15 : 0);
    fault = 2;
    run_full("bit0", 8'hAA, 1'b1, 1'b0, SC ? 14 : 0, SC ? 14 : 0);
    fault = 0;

    // Abort in the third SHL cycle.
    pattern = 8'h5A; dsr_val = 1'b1; dsl_val = 1'b1; start = 1'b1;
    push_run(8'h5A, 1'b1, 1'b1, S+4);
    push_idle(10);
    chk_n(1);
    start = 1'b0;
    chk_n(S+3);
    abort = 1'b1;
    chk_n(1);
    abort = 1'b0;
    chk_n(9);
    chk_err("abort_partial", 0, 0);
    run_full("after_abort", 8'h0F, 1'b0, 1'b1, 0, 0);

    // Start pulsed mid-SHR with different parameters must be ignored.
    pattern = 8'h3C; dsr_val = 1'b1; dsl_val = 1'b1; start = 1'b1;
    push_run(8'h3C, 1'b1, 1'b1, 2*S+5);
    push_idle(1);
    chk_n(1);
    start = 1'b0;
    chk_n(2);
    pattern = 8'hC3; dsr_val = 1'b0; dsl_val = 1'b0; start = 1'b1;
    chk_n(1);
    start = 1'b0;
    chk_n(2*S+1);
    chk_err("busy_start_done", 0, 0);
    chk_n(1);

    // Start and abort together while busy.
    pattern = 8'h81; dsr_val = 1'b0; dsl_val = 1'b1; start = 1'b1;
    push_run(8'h81, 1'b0, 1'b1, 5);
    push_idle(3);
    chk_n(1);
    start = 1'b0;
    chk_n(4);
    start = 1'b1; abort = 1'b1;
    chk_n(1);
    start = 1'b0; abort = 1'b0;
    chk_n(2);

    // Reset for one cycle in HOLD with errors already accumulated.
    fault = 1;
    pattern = 8'hAA; dsr_val = 1'b1; dsl_val = 1'b0; start = 1'b1;
    push_run(8'hAA, 1'b1, 1'b0, 2*S+2);
    push_idle(3);
    chk_n(1);
    start = 1'b0;
    chk_n(2*S+1);
    rst_n = 1'b0;
    chk_n(1);
    chk_err("mid_reset", 0, 0);
    rst_n = 1'b1;
    chk_n(2);
    fault = 0;
    run_full("after_reset", 8'hAA, 1'b1, 1'b0, 0, 0);

    check("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
